// File: rtl/core_seq.sv
// Per-core command responder: sequences INIT / RUN / REST / STDP phases over the
// synapse memory and neuron datapath, returning level completion flags to the controller.
module core_seq #(
    parameter int unsigned N_NEURON = 16,
    parameter int unsigned N_SYN    = 64,
    parameter int unsigned W_W      = 8,
    localparam int unsigned ADDR_W  = $clog2(N_NEURON * N_SYN),
    localparam int unsigned IDX_W   = $clog2(N_NEURON)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_run,
    input  logic              i_rest_run,
    input  logic              i_stdp_run,
    input  logic [W_W-1:0]    i_init_w,
    input  logic              i_nrn_spk,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [W_W-1:0]    o_mem_wdata,
    output logic              o_nrn_en,
    output logic              o_rest,
    output logic [IDX_W-1:0]  o_nrn_idx,
    output logic              o_inh_en,
    output logic [IDX_W-1:0]  o_winner,
    output logic              o_winner_vld,
    output logic              o_stdp_en,
    output logic              o_syn_done,
    output logic              o_inh_valid,
    output logic              o_stdp_done,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(N_NEURON * N_SYN - 1);
    localparam logic [ADDR_W-1:0] NRN_LAST  = ADDR_W'(N_NEURON - 1);
    localparam logic [ADDR_W-1:0] SYN_LAST  = ADDR_W'(N_SYN - 1);

    typedef enum logic [2:0] {StIdle, StInit, StIntg, StInhb, StRest, StStdp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last;
    logic              accept;
    logic [IDX_W-1:0]  winner_q;
    logic              winner_vld_q;
    logic              syn_done_q, inh_valid_q, stdp_done_q;
    logic [ADDR_W-1:0] stdp_addr;

    assign accept    = (state_q == StIdle) && (i_init || i_run || i_rest_run || i_stdp_run);
    assign stdp_addr = ADDR_W'(winner_q) * ADDR_W'(N_SYN) + cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_init)          state_d = StInit;
                else if (i_run)      state_d = StIntg;
                else if (i_rest_run) state_d = StRest;
                else if (i_stdp_run) state_d = StStdp;
            end
            StInit: begin
                last = (cnt_q == INIT_LAST);
                if (last) state_d = StIdle;
            end
            StIntg: begin
                last = (cnt_q == NRN_LAST);
                if (last) state_d = StInhb;
            end
            StInhb: state_d = StIdle;
            StRest: begin
                last = (cnt_q == NRN_LAST);
                if (last) state_d = StIdle;
            end
            StStdp: begin
                // Without a winner there is nothing to update: one idle-looking cycle.
                last = !winner_vld_q || (cnt_q == SYN_LAST);
                if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Counter restarts at 0 on every phase change.
        cnt_d = (state_d == state_q && state_q != StIdle) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q     <= '0;
            winner_vld_q <= 1'b0;
            syn_done_q   <= 1'b0;
            inh_valid_q  <= 1'b0;
            stdp_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                syn_done_q  <= 1'b0;
                inh_valid_q <= 1'b0;
                stdp_done_q <= 1'b0;
                if (i_init || i_run) begin
                    winner_q     <= '0;
                    winner_vld_q <= 1'b0;
                end
            end
            case (state_q)
                StInit: if (last) syn_done_q <= 1'b1;
                StIntg: begin
                    if (i_nrn_spk && !winner_vld_q) begin
                        winner_q     <= cnt_q[IDX_W-1:0];
                        winner_vld_q <= 1'b1;
                    end
                end
                StInhb: inh_valid_q <= 1'b1;
                StRest: if (last) inh_valid_q <= 1'b1;
                StStdp: if (last) stdp_done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_nrn_en   = 1'b0;
        o_rest     = 1'b0;
        o_nrn_idx  = '0;
        o_inh_en   = 1'b0;
        o_stdp_en  = 1'b0;
        case (state_q)
            StInit: begin
                o_mem_we   = 1'b1;
                o_mem_addr = cnt_q;
            end
            StIntg: begin
                o_nrn_en  = 1'b1;
                o_nrn_idx = cnt_q[IDX_W-1:0];
            end
            StInhb: o_inh_en = 1'b1;
            StRest: begin
                o_rest    = 1'b1;
                o_nrn_idx = cnt_q[IDX_W-1:0];
            end
            StStdp: begin
                if (winner_vld_q) begin
                    o_stdp_en  = 1'b1;
                    o_mem_addr = stdp_addr;
                end
            end
            default: ;
        endcase
    end

    assign o_mem_wdata  = o_mem_we ? i_init_w : '0;
    assign o_winner     = winner_q;
    assign o_winner_vld = winner_vld_q;
    assign o_syn_done   = syn_done_q;
    assign o_inh_valid  = inh_valid_q;
    assign o_stdp_done  = stdp_done_q;
    assign o_busy       = (state_q != StIdle);

endmodule
